// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing the data-cache request port among NumPorts requesters,
// with a TID pool that tags each accepted request and routes responses back to its owner.
module dcache_port_arbiter #(
  parameter int NumPorts     = 3,
  parameter int PayloadWidth = 64,
  parameter int TidWidth     = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumPorts-1:0]              port_req_i,
  input  logic [NumPorts*PayloadWidth-1:0] port_data_i,
  output logic [NumPorts-1:0]              port_gnt_o,
  output logic [NumPorts-1:0]              port_rvalid_o,
  output logic                             mem_req_o,
  input  logic                             mem_gnt_i,
  output logic [PayloadWidth-1:0]          mem_data_o,
  output logic [TidWidth-1:0]              mem_tid_o,
  input  logic                             mem_rvalid_i,
  input  logic [TidWidth-1:0]              mem_rtid_i,
  output logic [TidWidth:0]                outstanding_o,
  output logic                             spurious_o
);

  localparam int NT = 1 << TidWidth;
  localparam int PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic [NT-1:0]       busy_q, busy_d;
  logic [PW-1:0]       owner_q [NT];
  logic [PW-1:0]       owner_d [NT];
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic                lock_vld_q, lock_vld_d;
  logic [PW-1:0]       lock_port_q, lock_port_d;
  logic [TidWidth-1:0] lock_tid_q, lock_tid_d;
  logic                spurious_q, spurious_d;

  logic                any_sel;
  logic                use_lock;
  logic [PW-1:0]       sel;
  logic                any_free;
  logic [TidWidth-1:0] free_tid;
  logic                accept;
  logic                resp_hit;

  // Selection: a stalled (locked) request keeps priority, otherwise round-robin from rr_ptr.
  always_comb begin
    any_sel  = 1'b0;
    use_lock = 1'b0;
    sel      = '0;
    if (lock_vld_q && port_req_i[lock_port_q]) begin
      any_sel  = 1'b1;
      use_lock = 1'b1;
      sel      = lock_port_q;
    end else begin
      for (int i = 0; i < NumPorts; i++) begin
        if (!any_sel && port_req_i[(int'(rr_ptr_q) + i) % NumPorts]) begin
          any_sel = 1'b1;
          sel     = PW'((int'(rr_ptr_q) + i) % NumPorts);
        end
      end
    end
  end

  always_comb begin
    free_tid = '0;
    for (int t = NT - 1; t >= 0; t--) begin
      if (!busy_q[t]) free_tid = TidWidth'(t);
    end
    any_free = ~&busy_q;
  end

  always_comb begin
    outstanding_o = '0;
    for (int t = 0; t < NT; t++) begin
      outstanding_o = outstanding_o + (TidWidth+1)'(busy_q[t]);
    end
  end

  // The TID is frozen while stalled: a response freeing a lower TID must not change it.
  assign mem_req_o  = any_sel && any_free;
  assign mem_tid_o  = use_lock ? lock_tid_q : free_tid;
  assign mem_data_o = any_sel ? port_data_i[int'(sel)*PayloadWidth +: PayloadWidth] : '0;
  assign accept     = mem_req_o && mem_gnt_i;
  assign resp_hit   = mem_rvalid_i && busy_q[mem_rtid_i];
  assign spurious_o = spurious_q;

  always_comb begin
    port_gnt_o    = '0;
    port_rvalid_o = '0;
    if (accept)   port_gnt_o[sel] = 1'b1;
    if (resp_hit) port_rvalid_o[owner_q[mem_rtid_i]] = 1'b1;
  end

  always_comb begin
    busy_d      = busy_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    lock_vld_d  = 1'b0;
    lock_port_d = lock_port_q;
    lock_tid_d  = lock_tid_q;
    spurious_d  = mem_rvalid_i && !busy_q[mem_rtid_i];
    if (accept) begin
      busy_d[mem_tid_o]  = 1'b1;
      owner_d[mem_tid_o] = sel;
      rr_ptr_d           = (int'(sel) == NumPorts - 1) ? '0 : sel + PW'(1);
    end else if (mem_req_o) begin
      lock_vld_d  = 1'b1;
      lock_port_d = sel;
      lock_tid_d  = mem_tid_o;
    end
    if (resp_hit) busy_d[mem_rtid_i] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q      <= '0;
      rr_ptr_q    <= '0;
      lock_vld_q  <= 1'b0;
      lock_port_q <= '0;
      lock_tid_q  <= '0;
      spurious_q  <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_vld_q  <= lock_vld_d;
      lock_port_q <= lock_port_d;
      lock_tid_q  <= lock_tid_d;
      spurious_q  <= spurious_d;
    end
  end

  // Owner entries are only meaningful while their TID is busy, so they need no reset.
  always_ff @(posedge clk_i) begin
    owner_q <= owner_d;
  end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed scenarios followed by random traffic, checked cycle by cycle against a
// TID-pool reference model of the arbiter.
module tb_dcache_port_arbiter;

  localparam int NP = 3;
  localparam int DW = 64;
  localparam int TW = 2;
  localparam int NT = 1 << TW;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req;
  logic [DW-1:0]     p_data [NP];
  logic [NP*DW-1:0]  port_data;
  logic [NP-1:0]     port_gnt_o, port_rvalid_o;
  logic              mem_req_o, gnt, rvalid, spurious_o;
  logic [DW-1:0]     mem_data_o;
  logic [TW-1:0]     mem_tid_o, rtid;
  logic [TW:0]       outstanding_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_busy [NT];
  int m_owner [NT];
  int m_rr, m_lock, m_lock_tid;
  bit m_spur;

  // expectations of the current cycle
  bit e_any, e_req, e_acc, e_hit, e_lock;
  int e_sel, e_tid, e_free;

  always #5 clk = ~clk;

  assign port_data = {p_data[2], p_data[1], p_data[0]};

  dcache_port_arbiter #(.NumPorts(NP), .PayloadWidth(DW), .TidWidth(TW)) dut (
    .clk_i(clk), .rst_i(rst), .port_req_i(req), .port_data_i(port_data),
    .port_gnt_o(port_gnt_o), .port_rvalid_o(port_rvalid_o), .mem_req_o(mem_req_o),
    .mem_gnt_i(gnt), .mem_data_o(mem_data_o), .mem_tid_o(mem_tid_o),
    .mem_rvalid_i(rvalid), .mem_rtid_i(rtid), .outstanding_o(outstanding_o),
    .spurious_o(spurious_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++) m_busy[t] = 1'b0;
    m_rr = 0; m_lock = -1; m_lock_tid = 0; m_spur = 1'b0;
  endtask

  function automatic int busy_count();
    int n = 0;
    for (int t = 0; t < NT; t++) n += int'(m_busy[t]);
    return n;
  endfunction

  task automatic new_data();
    for (int p = 0; p < NP; p++) p_data[p] = {$urandom, $urandom};
  endtask

  // Evaluate the model 1 time unit after the falling edge and compare all outputs.
  task automatic eval();
    logic [63:0] exp_gnt, exp_rv;
    #1;
    if (rst) model_reset();
    e_any = 1'b0; e_lock = 1'b0; e_sel = 0;
    if (m_lock >= 0 && req[m_lock]) begin
      e_any = 1'b1; e_lock = 1'b1; e_sel = m_lock;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (!e_any && req[(m_rr + i) % NP]) begin
          e_any = 1'b1; e_sel = (m_rr + i) % NP;
        end
      end
    end
    e_free = -1;
    for (int t = NT - 1; t >= 0; t--) if (!m_busy[t]) e_free = t;
    e_req = e_any && (e_free >= 0);
    e_tid = e_lock ? m_lock_tid : e_free;
    e_acc = e_req && gnt;
    e_hit = rvalid && m_busy[rtid];
    exp_gnt = e_acc ? (64'd1 << e_sel) : 64'd0;
    exp_rv  = e_hit ? (64'd1 << m_owner[rtid]) : 64'd0;
    check("mem_req", 64'(mem_req_o), 64'(e_req));
    if (e_req) check("mem_tid", 64'(mem_tid_o), 64'(e_tid));
    check("mem_data", mem_data_o, e_any ? p_data[e_sel] : 64'd0);
    check("port_gnt", 64'(port_gnt_o), exp_gnt);
    check("port_rvalid", 64'(port_rvalid_o), exp_rv);
    check("outstanding", 64'(outstanding_o), 64'(busy_count()));
    check("spurious", 64'(spurious_o), 64'(m_spur));
  endtask

  task automatic advance();
    bit spur;
    @(posedge clk);
    if (!rst) begin
      spur = rvalid && !m_busy[rtid];
      if (e_acc) begin
        m_busy[e_tid] = 1'b1; m_owner[e_tid] = e_sel;
        m_rr = (e_sel + 1) % NP; m_lock = -1;
      end else if (e_req) begin
        m_lock = e_sel; m_lock_tid = e_tid;
      end else begin
        m_lock = -1;
      end
      if (e_hit) m_busy[rtid] = 1'b0;
      m_spur = spur;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; gnt = 1'b0; rvalid = 1'b0; rtid = '0;
    eval(); advance();
    eval(); advance();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; gnt = 1'b0; rvalid = 1'b0; rtid = '0;
    new_data();
    model_reset();
    @(negedge clk);

    // Reset: everything quiet
    do_reset();
    eval();
    check("rst_req", 64'(mem_req_o), 64'd0);
    check("rst_out", 64'(outstanding_o), 64'd0);
    advance();

    // All three requesting, always granted: p0,p1,p2,p0 with tids 0..3
    for (int k = 0; k < 4; k++) begin
      req = 3'b111; gnt = 1'b1; new_data();
      eval();
      check("t1_tid", 64'(mem_tid_o), 64'(k));
      check("t1_gnt", 64'(port_gnt_o), 64'd1 << (k % 3));
      advance();
    end
    // Pool full
    eval();
    check("t3_full_req", 64'(mem_req_o), 64'd0);
    check("t3_full_out", 64'(outstanding_o), 64'd4);
    advance();
    // Response on tid 2 goes to p2, tid 2 reissued next cycle to p1
    rvalid = 1'b1; rtid = 2'd2;
    eval();
    check("t3_rvalid", 64'(port_rvalid_o), 64'b100);
    advance();
    rvalid = 1'b0;
    eval();
    check("t3_reissue_tid", 64'(mem_tid_o), 64'd2);
    check("t3_reissue_gnt", 64'(port_gnt_o), 64'b010);
    advance();

    // Stall: p1 held for 3 cycles, p0 joins, p1 keeps the port
    do_reset();
    req = 3'b010; gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      new_data();
      eval();
      check("t2_stall_data", mem_data_o, p_data[1]);
      check("t2_stall_tid", 64'(mem_tid_o), 64'd0);
      advance();
    end
    req = 3'b011;
    eval();
    check("t2_lock_data", mem_data_o, p_data[1]);
    advance();
    gnt = 1'b1;
    eval();
    check("t2_gnt_p1", 64'(port_gnt_o), 64'b010);
    advance();
    req = 3'b001;
    eval();
    check("t2_gnt_p0", 64'(port_gnt_o), 64'b001);
    advance();

    // Same-cycle accept (p2) and response (tid 0, owned by p1)
    req = 3'b100; rvalid = 1'b1; rtid = 2'd0;
    eval();
    check("t4_gnt", 64'(port_gnt_o), 64'b100);
    check("t4_rvalid", 64'(port_rvalid_o), 64'b010);
    advance();
    req = '0; rvalid = 1'b0;
    eval();
    check("t4_out", 64'(outstanding_o), 64'd2);
    advance();

    // Response to a free tid
    rvalid = 1'b1; rtid = 2'd3;
    eval();
    check("t5_no_rvalid", 64'(port_rvalid_o), 64'd0);
    advance();
    rvalid = 1'b0;
    eval();
    check("t5_spur_hi", 64'(spurious_o), 64'd1);
    advance();
    eval();
    check("t5_spur_lo", 64'(spurious_o), 64'd0);
    advance();

    // Reset with three TIDs busy, then a stale response
    req = 3'b001; gnt = 1'b1;
    eval(); advance();
    req = '0;
    eval();
    check("t6_out_pre", 64'(outstanding_o), 64'd3);
    advance();
    rst = 1'b1;
    eval();
    check("t6_out_rst", 64'(outstanding_o), 64'd0);
    advance();
    rst = 1'b0;
    eval(); advance();
    rvalid = 1'b1; rtid = 2'd0;
    eval(); advance();
    rvalid = 1'b0;
    eval();
    check("t6_spur", 64'(spurious_o), 64'd1);
    advance();

    // Random traffic: requests held until granted, random grants and responses
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (e_acc && e_sel == p) req[p] = 1'b0;
        else if (!req[p] && $urandom_range(0, 2) == 0) req[p] = 1'b1;
      end
      gnt    = ($urandom_range(0, 9) < 7);
      rvalid = ($urandom_range(0, 9) < 4);
      rtid   = TW'($urandom_range(0, NT - 1));
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      new_data();
      eval(); advance();
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
